fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; low 2 bits SHALL be 0.
REQ-002 Parameter PC_STEP, default 4, PC increment per fetched instruction.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 redir  input  1  branch/jump redirect strobe, one cycle per redirect.
REQ-006 pc_in  input  32  redirect target, sampled when redir=1.
REQ-007 mem_req  output  1  instruction-memory read request.
REQ-008 mem_addr  output  32  read address; SHALL equal pc_q whenever mem_req=1.
REQ-009 mem_gnt  input  1  memory accepts request in the cycle where mem_req=1 and mem_gnt=1.
REQ-010 mem_rvalid  input  1  read data valid; exactly one per granted request, earliest 1 cycle after grant.
REQ-011 mem_rdata  input  32  read data, qualified by mem_rvalid.
REQ-012 instr_valid  output  1  fetched instruction available to decode.
REQ-013 instr  output  32  fetched instruction word.
REQ-014 instr_pc  output  32  address the instruction was fetched from.
REQ-015 instr_ready  input  1  decode consumes instruction when instr_valid=1 and instr_ready=1.
REQ-016 pc_q  output  32  current fetch PC register.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD; mem_req=1 only in REQ; instr_valid=1 only in HOLD.
REQ-018 IDLE SHALL go to REQ unconditionally on the first clock edge after reset release.
REQ-019 REQ: mem_req=1, mem_addr=pc_q; on mem_gnt=1 go to WAIT, else remain in REQ with request held stable.
REQ-020 WAIT: on mem_rvalid=1 capture instr<=mem_rdata, instr_pc<=pc_q, pc_q<=pc_q+PC_STEP, go to HOLD.
REQ-021 HOLD: instr, instr_pc SHALL be held stable; on instr_ready=1 go to REQ, instr_valid low the following cycle.
REQ-022 Minimum fetch throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and ready decode.
REQ-023 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-024 redir=1 in any state SHALL load pc_q<={pc_in[31:2],2'b00} on that edge.
REQ-025 redir in REQ without grant: stay in REQ, mem_addr SHALL show new PC next cycle.
REQ-026 redir in REQ coincident with mem_gnt: go to WAIT with discard flag set; the returning response SHALL be dropped.
REQ-027 redir in WAIT (with or without mem_rvalid same cycle): set discard flag if response pending; dropped response SHALL NOT update instr, instr_pc or pc_q.
REQ-028 After a dropped response the FSM SHALL go to REQ and fetch from the redirected PC.
REQ-029 redir in HOLD (regardless of instr_ready): go to REQ, instr_valid low next cycle; held instruction is discarded.
REQ-030 redir in IDLE: pc_q takes target; transition to REQ unchanged.
REQ-031 redir SHALL take priority over PC_STEP increment on the same edge.
REQ-032 mem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, pc_q=RESET_PC, mem_req=0, instr_valid=0, instr=0, instr_pc=0, discard flag=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it; a late mem_rvalid after release SHALL be ignored (FSM not in WAIT).

Verification
REQ-035 Reset release, mem_gnt=1, mem_rvalid 1 cycle after grant, rdata=32'h0000_0013, instr_ready=1 -> instr_valid with instr=32'h13, instr_pc=0, then mem_addr=4.
REQ-036 mem_gnt held low 5 cycles -> mem_req=1 and mem_addr=0 stable all 5 cycles; grant on cycle 6 -> WAIT.
REQ-037 instr_ready low 4 cycles in HOLD -> instr_valid=1, instr/instr_pc stable; no new mem_req until ready.
REQ-038 redir=1, pc_in=32'h0000_0103 during WAIT -> response dropped, next mem_addr=32'h0000_0100, instr_valid stays 0 until new response.
REQ-039 Fetch at pc_q=32'hFFFF_FFFC -> instr_pc=32'hFFFF_FFFC, next mem_addr=32'h0000_0000.
REQ-040 rst_n pulsed low in WAIT -> all outputs reset values asynchronously; mem_rvalid arriving after release ignored; first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, with a single-entry
// holding register toward decode and redirect handling that drops stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redir,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] pc_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_s;
    logic [31:0] instr_s;
    logic [31:0] instr_pc_s;
    logic        discard_r;
    logic        discard_s;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return target & 32'hFFFF_FFFC;
    endfunction

    assign mem_addr = pc_q;

    // Next-state, next-PC and capture logic; a redirect always overrides the increment.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_q;
        instr_s    = instr;
        instr_pc_s = instr_pc;
        discard_s  = discard_r;
        case (state_r)
            IDLE: begin
                state_s = REQ;
                if (redir) begin
                    pc_s = align_pc(pc_in);
                end else begin
                    pc_s = pc_q;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_s   = WAIT;
                    discard_s = redir;
                end else begin
                    state_s = REQ;
                end
                if (redir) begin
                    pc_s = align_pc(pc_in);
                end else begin
                    pc_s = pc_q;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    discard_s = 1'b0;
                    if (discard_r || redir) begin
                        // Stale response: drop it and refetch from the redirected PC.
                        state_s = REQ;
                        if (redir) begin
                            pc_s = align_pc(pc_in);
                        end else begin
                            pc_s = pc_q;
                        end
                    end else begin
                        state_s    = HOLD;
                        instr_s    = mem_rdata;
                        instr_pc_s = pc_q;
                        pc_s       = pc_q + STEP;
                    end
                end else begin
                    state_s = WAIT;
                    if (redir) begin
                        discard_s = 1'b1;
                        pc_s      = align_pc(pc_in);
                    end else begin
                        pc_s = pc_q;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    state_s = REQ;
                    pc_s    = align_pc(pc_in);
                end else if (instr_ready) begin
                    state_s = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s   = IDLE;
                discard_s = 1'b0;
            end
        endcase
    end

    // State, PC, instruction registers; mem_req/instr_valid are registered decodes of next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pc_q        <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            discard_r   <= 1'b0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_q        <= pc_s;
            instr       <= instr_s;
            instr_pc    <= instr_pc_s;
            discard_r   <= discard_s;
            mem_req     <= (state_s == REQ);
            instr_valid <= (state_s == HOLD);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level model compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redir;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] pc_q;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .redir(redir), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .pc_q(pc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // memory environment
    int          lat    = 1;
    int          rv_cnt = -1;
    logic [31:0] rd_addr;

    // transaction-level model
    logic [31:0] m_pc;
    logic        m_fresh;
    logic        m_out;
    logic        m_drop;
    logic        m_have;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_0000; m_fresh = 1'b1; m_out = 1'b0; m_drop = 1'b0;
        m_have = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic check_cycle();
        logic exp_req;
        exp_req = rst_n && !m_fresh && !m_out && !m_have;
        chk1("cyc_req", mem_req, exp_req);
        if (exp_req) chk("cyc_addr", mem_addr, m_pc);
        chk("cyc_pc_q", pc_q, m_pc);
        chk1("cyc_valid", instr_valid, m_have);
        if (m_have) begin
            chk("cyc_instr", instr, m_instr);
            chk("cyc_instr_pc", instr_pc, m_ipc);
        end
    endtask

    // Apply this cycle's inputs to the model (they take effect on the next edge).
    task automatic model_update();
        logic [31:0] tgt;
        tgt = {pc_in[31:2], 2'b00};
        if (!rst_n) begin
            model_reset();
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            if (redir) m_pc = tgt;
        end else if (m_have) begin
            if (redir) begin m_have = 1'b0; m_pc = tgt; end
            else if (instr_ready) m_have = 1'b0;
        end else if (m_out) begin
            if (mem_rvalid) begin
                m_out = 1'b0;
                if (m_drop || redir) begin
                    m_drop = 1'b0;
                    if (redir) m_pc = tgt;
                end else begin
                    m_have = 1'b1; m_instr = mem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                end
            end else if (redir) begin
                m_drop = 1'b1; m_pc = tgt;
            end
        end else begin
            if (mem_gnt) begin m_out = 1'b1; m_drop = redir; end
            if (redir) m_pc = tgt;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        if (rst_n && mem_req && mem_gnt) begin
            rv_cnt  = lat;
            rd_addr = mem_addr;
        end
        model_update();
        @(posedge clk);
        #1;
        redir      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(rd_addr);
                rv_cnt     = -1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; redir = 1'b0; pc_in = 32'h0; mem_gnt = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_q", pc_q, 32'h0000_0000);
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        rst_n = 1'b1;

        // basic fetch with zero-wait memory
        tick();
        chk1("t1_req", mem_req, 1'b1);
        chk("t1_addr", mem_addr, 32'h0000_0000);
        tick();
        tick();
        chk1("t1_valid", instr_valid, 1'b1);
        chk("t1_instr", instr, 32'h0000_0013);
        chk("t1_instr_pc", instr_pc, 32'h0000_0000);
        chk("t1_pc_q", pc_q, 32'h0000_0004);
        tick();
        chk1("t1_req2", mem_req, 1'b1);
        chk("t1_addr2", mem_addr, 32'h0000_0004);

        // grant withheld for 5 cycles, then decode stalls 4 cycles
        mem_gnt = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("t2_req_held", mem_req, 1'b1);
            chk("t2_addr_held", mem_addr, 32'h0000_0004);
        end
        mem_gnt = 1'b1;
        tick();
        chk1("t2_wait_noreq", mem_req, 1'b0);
        tick();
        chk1("t3_valid", instr_valid, 1'b1);
        chk("t3_instr", instr, 32'h0000_0017);
        chk("t3_instr_pc", instr_pc, 32'h0000_0004);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t3_valid_held", instr_valid, 1'b1);
            chk("t3_instr_held", instr, 32'h0000_0017);
            chk1("t3_noreq", mem_req, 1'b0);
        end
        instr_ready = 1'b1;
        tick();
        chk("t3_addr_next", mem_addr, 32'h0000_0008);

        // redirect while waiting: response dropped
        lat = 3;
        tick();
        redir = 1'b1; pc_in = 32'h0000_0103;
        tick();
        chk("t4_pc_q", pc_q, 32'h0000_0100);
        for (int i = 0; i < 8 && !mem_req; i++) tick();
        chk1("t4_req", mem_req, 1'b1);
        chk("t4_addr", mem_addr, 32'h0000_0100);
        chk1("t4_valid", instr_valid, 1'b0);
        lat = 1;
        tick();
        tick();
        chk("t4_instr", instr, 32'h0000_0113);
        chk("t4_instr_pc", instr_pc, 32'h0000_0100);
        tick();

        // redirect coincident with grant
        redir = 1'b1; pc_in = 32'h0000_0201;
        tick();
        tick();
        chk1("t5_req", mem_req, 1'b1);
        chk("t5_addr", mem_addr, 32'h0000_0200);
        chk1("t5_valid", instr_valid, 1'b0);

        // redirect in HOLD to the top word, then wraparound
        instr_ready = 1'b0;
        tick();
        tick();
        chk("t6_hold_pc", instr_pc, 32'h0000_0200);
        redir = 1'b1; pc_in = 32'hFFFF_FFFE;
        tick();
        chk1("t6_valid_drop", instr_valid, 1'b0);
        chk("t6_addr", mem_addr, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        tick();
        tick();
        chk("t6_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("t6_instr", instr, 32'hFFFF_FFEF);
        chk("t6_wrap_pc", pc_q, 32'h0000_0000);
        tick();
        chk("t6_wrap_addr", mem_addr, 32'h0000_0000);

        // redirect on the same cycle as the response
        tick();
        chk1("t6b_rvalid", mem_rvalid, 1'b1);
        redir = 1'b1; pc_in = 32'h0000_0300;
        tick();
        chk("t6b_addr", mem_addr, 32'h0000_0300);
        chk1("t6b_valid", instr_valid, 1'b0);

        // reset in WAIT, late response after release ignored
        lat = 4;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk1("t7_req", mem_req, 1'b0);
        chk1("t7_valid", instr_valid, 1'b0);
        chk("t7_instr", instr, 32'h0);
        chk("t7_instr_pc", instr_pc, 32'h0);
        chk("t7_pc_q", pc_q, 32'h0);
        tick();
        rst_n = 1'b1; mem_gnt = 1'b0;
        tick();
        tick();
        chk1("t7_late_rvalid", mem_rvalid, 1'b1);
        tick();
        chk1("t7_req_after", mem_req, 1'b1);
        chk("t7_addr_after", mem_addr, 32'h0000_0000);
        chk1("t7_valid_after", instr_valid, 1'b0);
        mem_gnt = 1'b1; lat = 1;
        tick();
        tick();
        chk("t7_instr_new", instr, 32'h0000_0013);
        chk("t7_instr_pc_new", instr_pc, 32'h0000_0000);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
